rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin tie-break,
// a registered write port, a pending-write scoreboard and a saturating conflict counter.
module rf_write_arbiter (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req0_valid,
    input  logic [4:0]  req0_wsel,
    input  logic [31:0] req0_wdat,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_wsel,
    input  logic [31:0] req1_wdat,
    output logic        req1_ready,
    input  logic        rsv_en,
    input  logic [4:0]  rsv_sel,
    input  logic        flush,
    output logic [31:0] busy,
    output logic        rf_WEN,
    output logic [4:0]  rf_wsel,
    output logic [31:0] rf_wdat,
    output logic [15:0] conflict_cnt
);

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_e;

    grant_e      last_grant_q, last_grant_d;
    logic        rf_wen_q, rf_wen_d;
    logic [4:0]  rf_wsel_q, rf_wsel_d;
    logic [31:0] rf_wdat_q, rf_wdat_d;
    logic [31:0] busy_q, busy_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    logic        grant0;
    logic        grant1;
    logic        wr_any;
    logic [4:0]  wr_sel;
    logic [31:0] wr_dat;

    // Grants are suppressed during reset so an in-flight request is never accepted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!n_rst) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q == GRANT_REQ1) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign wr_any = grant0 | grant1;
    assign wr_sel = grant1 ? req1_wsel : req0_wsel;
    assign wr_dat = grant1 ? req1_wdat : req0_wdat;

    always_comb begin
        last_grant_d   = last_grant_q;
        rf_wen_d       = 1'b0;
        rf_wsel_d      = rf_wsel_q;
        rf_wdat_d      = rf_wdat_q;
        busy_d         = busy_q;
        conflict_cnt_d = conflict_cnt_q;

        if (grant0) begin
            last_grant_d = GRANT_REQ0;
        end else if (grant1) begin
            last_grant_d = GRANT_REQ1;
        end

        if (wr_any) begin
            rf_wen_d  = (wr_sel != 5'd0);
            rf_wsel_d = wr_sel;
            rf_wdat_d = wr_dat;
            busy_d[wr_sel] = 1'b0;
        end

        // Ordering gives the reservation priority over a same-cycle clear, and flush over both.
        if (rsv_en && (rsv_sel != 5'd0)) begin
            busy_d[rsv_sel] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;

        if (req0_valid && req1_valid && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            last_grant_q   <= GRANT_REQ1;
            rf_wen_q       <= 1'b0;
            rf_wsel_q      <= '0;
            rf_wdat_q      <= '0;
            busy_q         <= '0;
            conflict_cnt_q <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            rf_wen_q       <= rf_wen_d;
            rf_wsel_q      <= rf_wsel_d;
            rf_wdat_q      <= rf_wdat_d;
            busy_q         <= busy_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign busy         = busy_q;
    assign rf_WEN       = rf_wen_q;
    assign rf_wsel      = rf_wsel_q;
    assign rf_wdat      = rf_wdat_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

    logic        clk;
    logic        n_rst;
    logic        req0_valid;
    logic [4:0]  req0_wsel;
    logic [31:0] req0_wdat;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_wsel;
    logic [31:0] req1_wdat;
    logic        req1_ready;
    logic        rsv_en;
    logic [4:0]  rsv_sel;
    logic        flush;
    logic [31:0] busy;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [15:0] conflict_cnt;

    int totalChecks;
    int badChecks;

    rf_write_arbiter dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req0_valid   (req0_valid),
        .req0_wsel    (req0_wsel),
        .req0_wdat    (req0_wdat),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_wsel    (req1_wsel),
        .req1_wdat    (req1_wdat),
        .req1_ready   (req1_ready),
        .rsv_en       (rsv_en),
        .rsv_sel      (rsv_sel),
        .flush        (flush),
        .busy         (busy),
        .rf_WEN       (rf_WEN),
        .rf_wsel      (rf_wsel),
        .rf_wdat      (rf_wdat),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expectation and tallies the result.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives all request inputs, then lets the combinational grant settle.
    task automatic applyStimulus(input logic v0, input logic [4:0] s0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] s1, input logic [31:0] d1,
                                 input logic rEn, input logic [4:0] rSel, input logic fl);
        req0_valid = v0;
        req0_wsel  = s0;
        req0_wdat  = d0;
        req1_valid = v1;
        req1_wsel  = s1;
        req1_wdat  = d1;
        rsv_en     = rEn;
        rsv_sel    = rSel;
        flush      = fl;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic doReset();
        n_rst = 1'b1;
        idleInputs();
        stepClock();
        n_rst = 1'b0;
    endtask

    initial begin
        totalChecks = 0;
        badChecks   = 0;

        // Reset with a request pending: no ready, all outputs cleared.
        n_rst = 1'b1;
        applyStimulus(1'b1, 5'd6, 32'h1111_2222, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
        stepClock();
        stepClock();
        checkOutput("rst_wen", {31'd0, rf_WEN}, 32'd0);
        checkOutput("rst_wsel", {27'd0, rf_wsel}, 32'd0);
        checkOutput("rst_wdat", rf_wdat, 32'd0);
        checkOutput("rst_busy", busy, 32'd0);
        checkOutput("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
        n_rst = 1'b0;
        idleInputs();
        stepClock();
        checkOutput("rst_nowrite", {31'd0, rf_WEN}, 32'd0);

        // Sole requester 1.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
        checkOutput("sole_ready1", {31'd0, req1_ready}, 32'd1);
        checkOutput("sole_ready0", {31'd0, req0_ready}, 32'd0);
        stepClock();
        checkOutput("sole_wen", {31'd0, rf_WEN}, 32'd1);
        checkOutput("sole_wsel", {27'd0, rf_wsel}, 32'd5);
        checkOutput("sole_wdat", rf_wdat, 32'hDEAD_BEEF);
        idleInputs();
        stepClock();
        checkOutput("idle_wen", {31'd0, rf_WEN}, 32'd0);
        checkOutput("idle_wsel_hold", {27'd0, rf_wsel}, 32'd5);
        checkOutput("idle_wdat_hold", rf_wdat, 32'hDEAD_BEEF);

        // Conflict after reset: requester 0 first, then alternating.
        doReset();
        applyStimulus(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd4, 32'hBBBB_0004, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("conf_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            checkOutput("conf_ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            stepClock();
            checkOutput("conf_wsel", {27'd0, rf_wsel}, (i % 2 == 0) ? 32'd3 : 32'd4);
            checkOutput("conf_wdat", rf_wdat, (i % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0004);
        end
        idleInputs();
        checkOutput("conf_cnt", {16'd0, conflict_cnt}, 32'd4);

        // Scoreboard set, clear, and same-cycle set-beats-clear.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
        stepClock();
        checkOutput("sb_set7", busy, 32'h0000_0080);
        applyStimulus(1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        stepClock();
        checkOutput("sb_clr7", busy, 32'h0000_0000);
        applyStimulus(1'b1, 5'd7, 32'h0000_0778, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
        stepClock();
        checkOutput("sb_setwins", busy, 32'h0000_0080);

        // Zero register write is accepted but never reaches the register file.
        applyStimulus(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0);
        checkOutput("zero_ready", {31'd0, req0_ready}, 32'd1);
        stepClock();
        checkOutput("zero_wen", {31'd0, rf_WEN}, 32'd0);
        checkOutput("zero_busy", busy, 32'h0000_0080);

        // Build busy=0xF0, then flush together with a reservation and a grant.
        for (int r = 4; r < 7; r++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 1'b0);
            stepClock();
        end
        checkOutput("fl_pre", busy, 32'h0000_00F0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h0000_0055, 1'b1, 5'd9, 1'b1);
        checkOutput("fl_ready1", {31'd0, req1_ready}, 32'd1);
        stepClock();
        checkOutput("fl_busy", busy, 32'd0);
        checkOutput("fl_wen", {31'd0, rf_WEN}, 32'd1);
        checkOutput("fl_wsel", {27'd0, rf_wsel}, 32'd2);

        // Reset mid-grant: request dropped, nothing written after release.
        n_rst = 1'b1;
        applyStimulus(1'b1, 5'd10, 32'h0000_0077, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0);
        checkOutput("midrst_ready0", {31'd0, req0_ready}, 32'd0);
        stepClock();
        checkOutput("midrst_wen", {31'd0, rf_WEN}, 32'd0);
        checkOutput("midrst_wsel", {27'd0, rf_wsel}, 32'd0);
        checkOutput("midrst_wdat", rf_wdat, 32'd0);
        checkOutput("midrst_busy", busy, 32'd0);
        n_rst = 1'b0;
        idleInputs();
        stepClock();
        checkOutput("midrst_nowrite", {31'd0, rf_WEN}, 32'd0);

        // Saturating conflict counter.
        doReset();
        applyStimulus(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 1'b0, 5'd0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        checkOutput("sat_fffe", {16'd0, conflict_cnt}, 32'h0000_FFFE);
        stepClock();
        checkOutput("sat_ffff", {16'd0, conflict_cnt}, 32'h0000_FFFF);
        repeat (4465) @(posedge clk);
        #1;
        checkOutput("sat_nowrap", {16'd0, conflict_cnt}, 32'h0000_FFFF);
        idleInputs();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
